// File: rtl/spi_slave_rx.sv
// SPI mode-0 MSB-first slave receiver with simultaneous miso return byte.
// All SPI pins are oversampled and synchronized into the clk domain.
module spi_slave_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              mosi,
    input  logic              cs_n,
    input  logic [DATA_W-1:0] tx_data,
    output logic              miso,
    output logic              tx_load,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        ACTIVE
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                   sck_d_q;
    logic                   cs_d_q;

    state_t              state_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [DATA_W-1:0]   rx_shreg_q;
    logic [DATA_W-1:0]   rx_shreg_d;
    logic [DATA_W-1:0]   tx_shreg_q;
    logic [DATA_W-1:0]   rx_data_q;
    logic                rx_valid_q;
    logic                tx_load_q;
    logic                frame_err_q;
    logic                busy_q;

    logic sck_s;
    logic mosi_s;
    logic cs_n_s;
    logic sck_rise;
    logic sck_fall;
    logic cs_rise;
    logic cs_fall;

    // Chains reset low so a held-low cs_n after reset never looks idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '0;
            sck_d_q     <= 1'b0;
            cs_d_q      <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            sck_d_q     <= sck_s;
            cs_d_q      <= cs_n_s;
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign cs_n_s   = cs_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d_q;
    assign sck_fall = ~sck_s & sck_d_q;
    assign cs_rise  = cs_n_s & ~cs_d_q;
    assign cs_fall  = ~cs_n_s & cs_d_q;

    assign rx_shreg_d = {rx_shreg_q[DATA_W-2:0], mosi_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_IDLE;
            bit_cnt_q   <= '0;
            rx_shreg_q  <= '0;
            tx_shreg_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_load_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            tx_load_q   <= 1'b0;
            frame_err_q <= 1'b0;
            unique case (state_q)
                WAIT_IDLE: begin
                    if (cs_n_s) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (cs_fall) begin
                        tx_shreg_q <= tx_data;
                        tx_load_q  <= 1'b1;
                        bit_cnt_q  <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // cs_n release wins over any same-cycle sck edge.
                    if (cs_rise) begin
                        frame_err_q <= (bit_cnt_q != '0);
                        bit_cnt_q   <= '0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else if (sck_rise) begin
                        rx_shreg_q <= rx_shreg_d;
                        if (bit_cnt_q == LAST_BIT) begin
                            rx_data_q  <= rx_shreg_d;
                            rx_valid_q <= 1'b1;
                            bit_cnt_q  <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else if (sck_fall) begin
                        if (bit_cnt_q == '0) begin
                            tx_shreg_q <= tx_data;
                            tx_load_q  <= 1'b1;
                        end else begin
                            tx_shreg_q <= {tx_shreg_q[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                default: begin
                    state_q <= WAIT_IDLE;
                end
            endcase
        end
    end

    assign miso      = busy_q & tx_shreg_q[DATA_W-1];
    assign tx_load   = tx_load_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: directed frame table, hand-written corner
// sequences and randomized frames checked against a byte-level model.
module tb_spi_slave_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       sck;
    logic       mosi;
    logic       cs_n;
    logic [7:0] tx_data;
    logic       miso;
    logic       tx_load;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .cs_n(cs_n),
        .tx_data(tx_data), .miso(miso), .tx_load(tx_load),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Output event monitor
    logic [7:0] got_rx[$];
    int n_load = 0;
    int n_err  = 0;

    always @(negedge clk) begin
        if (rx_valid) got_rx.push_back(rx_data);
        if (tx_load) n_load++;
        if (frame_err) n_err++;
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        got_rx.delete();
        n_load = 0;
        n_err  = 0;
    endtask

    // Frame stimulus: full bytes from snd_q, return bytes from txv_q,
    // then pbits leading bits of pbyte before releasing cs_n.
    logic [7:0] snd_q[$];
    logic [7:0] txv_q[$];
    logic [7:0] miso_q[$];
    logic [7:0] last_rx;
    logic       busy_mid;

    task automatic send_bit(input logic b, output logic m);
        mosi = b;
        clks(4);
        m   = miso;
        sck = 1'b1;
    endtask

    task automatic run_frame(input int pbits, input logic [7:0] pbyte);
        logic [7:0] m;
        logic [7:0] cur;
        logic       mb;
        clear_counts();
        miso_q.delete();
        if (txv_q.size() > 0) tx_data = txv_q[0];
        cs_n = 1'b0;
        clks(6);
        for (int k = 0; k < snd_q.size(); k++) begin
            cur = snd_q[k];
            m   = '0;
            for (int b = 7; b >= 0; b--) begin
                send_bit(cur[b], mb);
                m[b] = mb;
                if (b == 7 && k + 1 < txv_q.size()) tx_data = txv_q[k+1];
                clks(4);
                sck = 1'b0;
            end
            miso_q.push_back(m);
        end
        for (int b = 0; b < pbits; b++) begin
            send_bit(pbyte[7-b], mb);
            clks(4);
            sck = 1'b0;
        end
        busy_mid = busy;
        clks(4);
        cs_n = 1'b1;
        clks(8);
    endtask

    // Model: each complete byte appears once on rx, each return byte
    // appears on miso, one load at cs fall plus one per completed byte,
    // and a frame error iff the frame ended mid-byte.
    task automatic verify(input string tag, input int pbits);
        check({tag, " rx_count"}, got_rx.size(), snd_q.size());
        for (int k = 0; k < snd_q.size(); k++) begin
            if (k < got_rx.size())
                check($sformatf("%s rx[%0d]", tag, k), got_rx[k], snd_q[k]);
            if (k < txv_q.size())
                check($sformatf("%s miso[%0d]", tag, k), miso_q[k], txv_q[k]);
        end
        if (snd_q.size() > 0) last_rx = snd_q[snd_q.size()-1];
        check({tag, " frame_err"}, n_err, (pbits % 8 != 0) ? 1 : 0);
        check({tag, " tx_load"}, n_load, 1 + snd_q.size());
        check({tag, " rx_data_hold"}, rx_data, last_rx);
        check({tag, " busy_mid"}, busy_mid, 1'b1);
        check({tag, " busy_end"}, busy, 1'b0);
        check({tag, " miso_end"}, miso, 1'b0);
    endtask

    typedef struct {
        int         nfull;
        logic [7:0] mo;
        logic [7:0] tx;
        int         pbits;
        logic [7:0] pb;
        int         exp_valid;
        int         exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1, 8'hAB, 8'h00, 0, 8'h00, 1, 0};
        vecs[1] = '{1, 8'h3C, 8'h5A, 0, 8'h00, 1, 0};
        vecs[2] = '{0, 8'h00, 8'h00, 5, 8'hFF, 0, 1};
        vecs[3] = '{1, 8'h96, 8'hA5, 0, 8'h00, 1, 0};
        vecs[4] = '{1, 8'hFF, 8'h00, 0, 8'h00, 1, 0};
        vecs[5] = '{1, 8'h00, 8'hFF, 3, 8'hA0, 1, 1};

        rst = 1'b1; sck = 1'b0; mosi = 1'b0; cs_n = 1'b1; tx_data = 8'h00;
        last_rx = 8'h00;
        clks(3);
        check("reset miso", miso, 1'b0);
        check("reset tx_load", tx_load, 1'b0);
        check("reset rx_data", rx_data, 8'h00);
        check("reset rx_valid", rx_valid, 1'b0);
        check("reset frame_err", frame_err, 1'b0);
        check("reset busy", busy, 1'b0);
        rst = 1'b0;
        clks(6);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            snd_q.delete(); txv_q.delete();
            if (vecs[i].nfull > 0) begin
                snd_q.push_back(vecs[i].mo);
                txv_q.push_back(vecs[i].tx);
            end
            run_frame(vecs[i].pbits, vecs[i].pb);
            check($sformatf("vec%0d nvalid", i), got_rx.size(), vecs[i].exp_valid);
            check($sformatf("vec%0d nerr", i), n_err, vecs[i].exp_err);
            verify($sformatf("vec%0d", i), vecs[i].pbits);
        end

        // Back-to-back bytes under one cs_n low
        snd_q = '{8'hAB, 8'hCD};
        txv_q = '{8'h11, 8'h22};
        run_frame(0, 8'h00);
        verify("b2b", 0);

        // Reset mid-frame with cs_n held low
        clear_counts();
        tx_data = 8'h77;
        cs_n = 1'b0;
        clks(6);
        for (int b = 0; b < 3; b++) begin
            logic mb;
            send_bit(1'b1, mb);
            clks(4);
            sck = 1'b0;
        end
        rst = 1'b1;
        clks(1);
        rst = 1'b0;
        clear_counts();
        last_rx = 8'h00;
        for (int b = 0; b < 5; b++) begin
            logic mb;
            send_bit(1'b1, mb);
            clks(2);
            check($sformatf("rst busy b%0d", b), busy, 1'b0);
            clks(2);
            sck = 1'b0;
        end
        clks(4);
        check("rst nvalid", got_rx.size(), 0);
        check("rst nload", n_load, 0);
        check("rst nerr", n_err, 0);
        check("rst rx_data", rx_data, 8'h00);
        check("rst miso", miso, 1'b0);
        cs_n = 1'b1;
        clks(8);
        snd_q = '{8'hC3};
        txv_q = '{8'h3C};
        run_frame(0, 8'h00);
        verify("post_rst", 0);

        // sck activity with cs_n high is ignored
        clear_counts();
        for (int e = 0; e < 16; e++) begin
            sck  = ~sck;
            mosi = e[1];
            clks(4);
            if (e == 8) begin
                check("idle busy", busy, 1'b0);
                check("idle miso", miso, 1'b0);
            end
        end
        clks(6);
        check("idle nvalid", got_rx.size(), 0);
        check("idle nload", n_load, 0);
        check("idle nerr", n_err, 0);
        check("idle rx_data", rx_data, last_rx);

        // Randomized frames against the byte-level model
        for (int r = 0; r < 25; r++) begin
            int nf;
            int pb;
            snd_q.delete(); txv_q.delete();
            nf = $urandom_range(1, 3);
            pb = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7);
            for (int k = 0; k < nf; k++) begin
                snd_q.push_back(8'($urandom));
                txv_q.push_back(8'($urandom));
            end
            run_frame(pb, 8'($urandom));
            verify($sformatf("rnd%0d", r), pb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
